// File: rtl/hazard_scoreboard_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit_pkg
// Shared encodings for the MIPS hazard unit: the opcode/funct values the hazard
// logic decodes, the hazard FSM state encoding, and a jump-decode helper.
// No ports (package).
// -----------------------------------------------------------------------------
package hazard_scoreboard_unit_pkg;

   localparam logic [5:0] OPCODE_R_TYPE = 6'h00;
   localparam logic [5:0] OPCODE_J      = 6'h02;
   localparam logic [5:0] OPCODE_JAL    = 6'h03;
   localparam logic [5:0] OPCODE_HALT   = 6'h3F;
   localparam logic [5:0] FUNC_JR       = 6'h08;
   localparam logic [5:0] FUNC_JALR     = 6'h09;

   typedef enum logic [1:0] {
      HZ_ST_RUN    = 2'b00,
      HZ_ST_DRAIN  = 2'b01,
      HZ_ST_HALTED = 2'b10
   } hz_state_t;

   // True for J, JAL and the register jumps JR/JALR (unqualified by valid).
   function automatic logic is_jump_op(input logic [5:0] opcode,
                                       input logic [5:0] funct);
      logic jump;
      jump = 1'b0;
      if ((opcode == OPCODE_J) || (opcode == OPCODE_JAL)) begin
         jump = 1'b1;
      end else if (opcode == OPCODE_R_TYPE) begin
         jump = (funct == FUNC_JR) || (funct == FUNC_JALR);
      end else begin
         jump = 1'b0;
      end
      return jump;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_load_scoreboard.sv
// -----------------------------------------------------------------------------
// load_scoreboard
// One 4-bit countdown per architectural register tracking how many more
// bubbles a consumer of an in-flight load result must wait, plus a pending
// lookup for two read ports. A load currently in EX counts as pending for its
// destination in the same cycle, so the first bubble needs no stored state.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   ex_valid, ex_mem_read   EX holds a real load
//   ex_rt                   load destination register
//   rd_a, rd_b              registers looked up by the two read ports
//   pend_a, pend_b          register has a load result still outstanding
// -----------------------------------------------------------------------------
module load_scoreboard #(
   parameter int REG_ADDR_W   = 5,
   parameter int LOAD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ex_valid,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic [REG_ADDR_W-1:0] rd_a,
   input  logic [REG_ADDR_W-1:0] rd_b,
   output logic                  pend_a,
   output logic                  pend_b
);
   import hazard_scoreboard_unit_pkg::*;

   localparam int NUM_REGS = 1 << REG_ADDR_W;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};
   // After the EX cycle itself, LOAD_LATENCY-1 more bubbles remain.
   localparam logic [3:0] CNT_LOAD = 4'(LOAD_LATENCY - 1);

   logic [3:0] cnt_r [NUM_REGS];
   logic       load_ex_s;

   assign load_ex_s = ex_valid & ex_mem_read & (ex_rt != REG_ZERO);

   // Countdown array: a new load reloads its entry (winning over the decrement).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            cnt_r[i] <= 4'd0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (load_ex_s && (ex_rt == REG_ADDR_W'(i))) begin
               cnt_r[i] <= CNT_LOAD;
            end else if (cnt_r[i] != 4'd0) begin
               cnt_r[i] <= cnt_r[i] - 4'd1;
            end else begin
               cnt_r[i] <= cnt_r[i];
            end
         end
      end
   end

   assign pend_a = (rd_a != REG_ZERO) &
                   ((load_ex_s & (ex_rt == rd_a)) | (cnt_r[rd_a] != 4'd0));
   assign pend_b = (rd_b != REG_ZERO) &
                   ((load_ex_s & (ex_rt == rd_b)) | (cnt_r[rd_b] != 4'd0));

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit
// Hazard unit beside the ID stage: detects load-use hazards through a
// per-register scoreboard, resolves mispredict > stall > jump priority, drains
// the pipeline after HALT and keeps saturating stall/flush counters.
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_id_*                          ID instruction: valid, rs/rt, use flags, opcode/funct
//   i_ex_valid/mem_read/rt          EX load information
//   i_ex_mispredict                 EX branch resolved mispredicted
//   o_stall, o_flush_if_id,
//   o_flush_id_ex, o_jump_redirect  pipeline control, valid in the same cycle
//   o_freeze, o_halted              HALT drain status
//   o_stall_count, o_flush_count    saturating performance counters
// -----------------------------------------------------------------------------
module hazard_scoreboard_unit #(
   parameter int REG_ADDR_W   = 5,
   parameter int LOAD_LATENCY = 1,
   parameter int DRAIN_DEPTH  = 3,
   parameter int CNT_W        = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_id_valid,
   input  logic [REG_ADDR_W-1:0] i_id_rs,
   input  logic [REG_ADDR_W-1:0] i_id_rt,
   input  logic                  i_id_use_rs,
   input  logic                  i_id_use_rt,
   input  logic [5:0]            i_id_opcode,
   input  logic [5:0]            i_id_funct,
   input  logic                  i_ex_valid,
   input  logic                  i_ex_mem_read,
   input  logic [REG_ADDR_W-1:0] i_ex_rt,
   input  logic                  i_ex_mispredict,
   output logic                  o_stall,
   output logic                  o_flush_if_id,
   output logic                  o_flush_id_ex,
   output logic                  o_jump_redirect,
   output logic                  o_freeze,
   output logic                  o_halted,
   output logic [CNT_W-1:0]      o_stall_count,
   output logic [CNT_W-1:0]      o_flush_count
);
   import hazard_scoreboard_unit_pkg::*;

   localparam logic [3:0]       DRAIN_LOAD = 4'(DRAIN_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

   logic       pend_rs_s;
   logic       pend_rt_s;
   logic       run_s;
   logic       hazard_s;
   logic       is_jump_s;
   logic       mis_eff_s;
   logic       halt_go_s;
   logic       stall_s;
   logic       flush_if_id_s;
   logic       flush_id_ex_s;
   logic       jump_redirect_s;
   hz_state_t  state_r;
   hz_state_t  state_nxt_s;
   logic [3:0] drain_cnt_r;
   logic [3:0] drain_nxt_s;

   load_scoreboard #(
      .REG_ADDR_W   (REG_ADDR_W),
      .LOAD_LATENCY (LOAD_LATENCY)
   ) u_load_scoreboard (
      .clk         (i_clk),
      .rst_n       (i_rst_n),
      .ex_valid    (i_ex_valid),
      .ex_mem_read (i_ex_mem_read),
      .ex_rt       (i_ex_rt),
      .rd_a        (i_id_rs),
      .rd_b        (i_id_rt),
      .pend_a      (pend_rs_s),
      .pend_b      (pend_rt_s)
   );

   assign run_s     = (state_r == HZ_ST_RUN);
   assign hazard_s  = i_id_valid & ((i_id_use_rs & pend_rs_s) | (i_id_use_rt & pend_rt_s));
   assign is_jump_s = i_id_valid & is_jump_op(i_id_opcode, i_id_funct);
   // Once HALT has left ID nothing older can still mispredict.
   assign mis_eff_s = i_ex_mispredict & run_s;
   // A HALT that is itself stalled or squashed must not start the drain.
   assign halt_go_s = run_s & i_id_valid & (i_id_opcode == OPCODE_HALT) &
                      ~mis_eff_s & ~hazard_s;

   // Control priority: mispredict over load-use stall over jump redirect.
   always_comb begin
      stall_s         = 1'b0;
      flush_if_id_s   = 1'b0;
      flush_id_ex_s   = 1'b0;
      jump_redirect_s = 1'b0;
      if (!run_s) begin
         stall_s         = 1'b0;
      end else if (mis_eff_s) begin
         flush_if_id_s   = 1'b1;
         flush_id_ex_s   = 1'b1;
      end else if (hazard_s) begin
         // A JR/JALR waiting on a load stalls here rather than redirecting.
         stall_s         = 1'b1;
      end else if (is_jump_s) begin
         jump_redirect_s = 1'b1;
         flush_if_id_s   = 1'b1;
      end else begin
         stall_s         = 1'b0;
      end
   end

   // FSM state and drain counter registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r     <= HZ_ST_RUN;
         drain_cnt_r <= 4'd0;
      end else begin
         state_r     <= state_nxt_s;
         drain_cnt_r <= drain_nxt_s;
      end
   end

   // FSM next state: RUN -> DRAIN on an accepted HALT, DRAIN counts down to HALTED.
   always_comb begin
      state_nxt_s = state_r;
      drain_nxt_s = drain_cnt_r;
      case (state_r)
         HZ_ST_RUN: begin
            if (halt_go_s) begin
               state_nxt_s = HZ_ST_DRAIN;
               drain_nxt_s = DRAIN_LOAD;
            end else begin
               state_nxt_s = HZ_ST_RUN;
            end
         end
         HZ_ST_DRAIN: begin
            if (drain_cnt_r == 4'd0) begin
               state_nxt_s = HZ_ST_HALTED;
            end else begin
               drain_nxt_s = drain_cnt_r - 4'd1;
            end
         end
         HZ_ST_HALTED: begin
            state_nxt_s = HZ_ST_HALTED;
         end
         default: begin
            state_nxt_s = HZ_ST_RUN;
            drain_nxt_s = 4'd0;
         end
      endcase
   end

   // Outputs are held low while reset is asserted, whatever the inputs do.
   assign o_stall         = i_rst_n & stall_s;
   assign o_flush_if_id   = i_rst_n & flush_if_id_s;
   assign o_flush_id_ex   = i_rst_n & flush_id_ex_s;
   assign o_jump_redirect = i_rst_n & jump_redirect_s;
   assign o_freeze        = i_rst_n & (state_r != HZ_ST_RUN);
   assign o_halted        = i_rst_n & (state_r == HZ_ST_HALTED);

   // Saturating stall and flush event counters.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_stall_count <= {CNT_W{1'b0}};
         o_flush_count <= {CNT_W{1'b0}};
      end else begin
         if (o_stall && (o_stall_count != CNT_MAX)) begin
            o_stall_count <= o_stall_count + CNT_ONE;
         end else begin
            o_stall_count <= o_stall_count;
         end
         if (o_flush_if_id && (o_flush_count != CNT_MAX)) begin
            o_flush_count <= o_flush_count + CNT_ONE;
         end else begin
            o_flush_count <= o_flush_count;
         end
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard_unit
// Two instances share stimulus: LOAD_LATENCY=1/DRAIN_DEPTH=2/CNT_W=4 (counter
// saturation reachable) and LOAD_LATENCY=3/DRAIN_DEPTH=3/CNT_W=32. The
// reference model records, per register, the first cycle a loaded value is
// usable, and the cycle HALT was accepted; all expectations follow from those.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard_unit;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_JAL  = 6'h03;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_HALT = 6'h3F;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_JALR = 6'h09;
   localparam logic [5:0] FN_ADD  = 6'h20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       id_valid = 1'b0;
   logic [4:0] id_rs = 5'd0;
   logic [4:0] id_rt = 5'd0;
   logic       id_use_rs = 1'b0;
   logic       id_use_rt = 1'b0;
   logic [5:0] id_opcode = 6'd0;
   logic [5:0] id_funct = 6'd0;
   logic       ex_valid = 1'b0;
   logic       ex_mem_read = 1'b0;
   logic [4:0] ex_rt = 5'd0;
   logic       ex_mispredict = 1'b0;

   logic        st0, fi0, fe0, jr0, fz0, hl0;
   logic [3:0]  sc0, fc0;
   logic        st1, fi1, fe1, jr1, fz1, hl1;
   logic [31:0] sc1, fc1;

   always #5 clk = ~clk;

   hazard_scoreboard_unit #(.REG_ADDR_W(5), .LOAD_LATENCY(1), .DRAIN_DEPTH(2), .CNT_W(4)) dut_l1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
      .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt), .i_id_opcode(id_opcode), .i_id_funct(id_funct),
      .i_ex_valid(ex_valid), .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt), .i_ex_mispredict(ex_mispredict),
      .o_stall(st0), .o_flush_if_id(fi0), .o_flush_id_ex(fe0), .o_jump_redirect(jr0),
      .o_freeze(fz0), .o_halted(hl0), .o_stall_count(sc0), .o_flush_count(fc0));

   hazard_scoreboard_unit #(.REG_ADDR_W(5), .LOAD_LATENCY(3), .DRAIN_DEPTH(3), .CNT_W(32)) dut_l3 (
      .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
      .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt), .i_id_opcode(id_opcode), .i_id_funct(id_funct),
      .i_ex_valid(ex_valid), .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt), .i_ex_mispredict(ex_mispredict),
      .o_stall(st1), .o_flush_if_id(fi1), .o_flush_id_ex(fe1), .o_jump_redirect(jr1),
      .o_freeze(fz1), .o_halted(hl1), .o_stall_count(sc1), .o_flush_count(fc1));

   // Reference model state
   int     lat  [2] = '{1, 3};
   int     drn  [2] = '{2, 3};
   longint cmax [2] = '{64'd15, 64'hFFFF_FFFF};
   int     ready_cyc [2][32];
   int     halt_cyc [2];
   longint scnt [2];
   longint fcnt [2];
   int     cyc = 0;
   int     checks = 0;
   int     errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit pend_m(input int k, input logic [4:0] r);
      bit ld;
      ld = ex_valid && ex_mem_read && (ex_rt != 5'd0);
      return (r != 5'd0) && ((ld && (ex_rt == r)) || (cyc < ready_cyc[k][r]));
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < 32; r++) ready_cyc[k][r] = 0;
         halt_cyc[k] = -1;
         scnt[k] = 0;
         fcnt[k] = 0;
      end
   endtask

   task automatic drv(input bit iv, input logic [4:0] rs, input logic [4:0] rt,
                      input bit urs, input bit urt, input logic [5:0] op, input logic [5:0] fn,
                      input bit ev, input bit mr, input logic [4:0] ert, input bit mis);
      id_valid = iv; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
      id_opcode = op; id_funct = fn; ex_valid = ev; ex_mem_read = mr; ex_rt = ert;
      ex_mispredict = mis;
   endtask

   // Called just after a falling edge: compare, advance one rising edge, return after the next fall.
   task automatic step();
      bit run [2], hz [2], mis [2], st [2], fi [2];
      bit frz, hlt, jmp, ld;
      logic [5:0]  ov, ev;
      logic [31:0] osc, ofc;
      #1;
      ld  = ex_valid && ex_mem_read && (ex_rt != 5'd0);
      jmp = id_valid && ((id_opcode == OP_J) || (id_opcode == OP_JAL) ||
            ((id_opcode == OP_R) && ((id_funct == FN_JR) || (id_funct == FN_JALR))));
      for (int k = 0; k < 2; k++) begin
         frz = (halt_cyc[k] >= 0) && (cyc > halt_cyc[k]);
         hlt = (halt_cyc[k] >= 0) && (cyc >= halt_cyc[k] + 1 + drn[k]);
         run[k] = !frz;
         hz[k]  = id_valid && ((id_use_rs && pend_m(k, id_rs)) || (id_use_rt && pend_m(k, id_rt)));
         mis[k] = ex_mispredict && run[k];
         st[k]  = run[k] && !mis[k] && hz[k];
         fi[k]  = run[k] && (mis[k] || (!hz[k] && jmp));
         ev = {st[k], fi[k], mis[k], run[k] && !mis[k] && !hz[k] && jmp, frz, hlt};
         if (k == 0) begin
            ov = {st0, fi0, fe0, jr0, fz0, hl0}; osc = {28'd0, sc0}; ofc = {28'd0, fc0};
         end else begin
            ov = {st1, fi1, fe1, jr1, fz1, hl1}; osc = sc1; ofc = fc1;
         end
         check($sformatf("L%0d outs{stall,fif,fie,jr,frz,hlt}", lat[k]), {26'd0, ov}, {26'd0, ev});
         check($sformatf("L%0d stall_count", lat[k]), osc, 32'(scnt[k]));
         check($sformatf("L%0d flush_count", lat[k]), ofc, 32'(fcnt[k]));
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (ld) ready_cyc[k][ex_rt] = cyc + lat[k];
         if (run[k] && id_valid && (id_opcode == OP_HALT) && !mis[k] && !hz[k]) halt_cyc[k] = cyc;
         if (st[k] && (scnt[k] < cmax[k])) scnt[k]++;
         if (fi[k] && (fcnt[k] < cmax[k])) fcnt[k]++;
      end
      cyc++;
      @(negedge clk);
   endtask

   // Called just after a falling edge; asserts reset asynchronously and releases on a falling edge.
   task automatic reset_dut();
      rst_n = 1'b0;
      #1;
      check("rst L1 outs", {26'd0, st0, fi0, fe0, jr0, fz0, hl0}, 32'd0);
      check("rst L1 counts", {24'd0, sc0, fc0}, 32'd0);
      check("rst L3 outs", {26'd0, st1, fi1, fe1, jr1, fz1, hl1}, 32'd0);
      check("rst L3 counts", sc1 | fc1, 32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      reset_dut();

      // Load r5 in EX, dependent add in ID on rs=r5
      drv(1, 5'd5, 5'd0, 1, 0, OP_R, FN_ADD, 1, 1, 5'd5, 0); step();
      repeat (3) begin drv(1, 5'd5, 5'd0, 1, 0, OP_R, FN_ADD, 0, 0, 5'd0, 0); step(); end
      check("L1 load-use stall total", {28'd0, sc0}, 32'd1);
      check("L3 load-use stall total", sc1, 32'd3);

      // Same sequence but rs not read
      reset_dut();
      drv(1, 5'd5, 5'd0, 0, 0, OP_R, FN_ADD, 1, 1, 5'd5, 0); step();
      repeat (3) begin drv(1, 5'd5, 5'd0, 0, 0, OP_R, FN_ADD, 0, 0, 5'd0, 0); step(); end

      // Load to r0 never pends; JR r7 behind a load stalls then redirects
      drv(1, 5'd0, 5'd0, 1, 1, OP_R, FN_ADD, 1, 1, 5'd0, 0); step();
      drv(1, 5'd7, 5'd0, 1, 0, OP_R, FN_JR, 1, 1, 5'd7, 0); step();
      repeat (3) begin drv(1, 5'd7, 5'd0, 1, 0, OP_R, FN_JR, 0, 0, 5'd0, 0); step(); end
      drv(1, 5'd0, 5'd0, 0, 0, OP_JAL, 6'd0, 0, 0, 5'd0, 0); step();

      // Mispredict overrides a hazard on r5
      reset_dut();
      drv(1, 5'd5, 5'd0, 1, 0, OP_R, FN_ADD, 1, 1, 5'd5, 1); step();
      drv(0, 5'd0, 5'd0, 0, 0, OP_R, 6'd0, 0, 0, 5'd0, 0); step();
      check("L1 flush after mispredict", {28'd0, fc0}, 32'd1);
      check("L3 flush after mispredict", fc1, 32'd1);

      // Stall counter saturation on the 4-bit instance
      reset_dut();
      repeat (20) begin drv(1, 5'd5, 5'd0, 1, 0, OP_R, FN_ADD, 1, 1, 5'd5, 0); step(); end
      check("L1 stall_count saturated", {28'd0, sc0}, 32'd15);
      check("L3 stall_count 20", sc1, 32'd20);

      // HALT drain, mispredict ignored, halted sticky
      reset_dut();
      drv(1, 5'd0, 5'd0, 0, 0, OP_HALT, 6'd0, 0, 0, 5'd0, 0); step();
      drv(1, 5'd3, 5'd0, 1, 0, OP_J, 6'd0, 1, 1, 5'd3, 1); step();
      repeat (6) begin drv(1, 5'd3, 5'd4, 1, 1, OP_R, FN_JR, 1, 1, 5'd4, 1); step(); end
      check("L1 halted sticky", {31'd0, hl0}, 32'd1);
      check("L3 halted sticky", {31'd0, hl1}, 32'd1);

      // Reset during DRAIN with counters nonzero
      reset_dut();
      drv(1, 5'd5, 5'd0, 1, 0, OP_R, FN_ADD, 1, 1, 5'd5, 0); step();
      drv(1, 5'd9, 5'd0, 0, 0, OP_HALT, 6'd0, 0, 0, 5'd0, 0); step();
      drv(0, 5'd0, 5'd0, 0, 0, OP_R, 6'd0, 0, 0, 5'd0, 1); step();
      reset_dut();
      check("counts clear after reset", {24'd0, sc0, fc0} | sc1 | fc1, 32'd0);
      drv(0, 5'd0, 5'd0, 0, 0, OP_R, 6'd0, 0, 0, 5'd0, 0); step();

      // Randomized traffic with occasional mid-run resets
      for (int n = 0; n < 3000; n++) begin
         logic [5:0] ops [6];
         logic [5:0] fns [3];
         ops = '{OP_R, OP_R, OP_J, OP_JAL, OP_LW, OP_ADDI};
         fns = '{FN_ADD, FN_JR, FN_JALR};
         if ($urandom_range(0, 299) == 0) reset_dut();
         id_valid      = ($urandom_range(0, 9) < 8);
         id_rs         = 5'($urandom_range(0, 7));
         id_rt         = 5'($urandom_range(0, 7));
         id_use_rs     = 1'($urandom_range(0, 1));
         id_use_rt     = 1'($urandom_range(0, 1));
         id_opcode     = ($urandom_range(0, 99) < 2) ? OP_HALT : ops[$urandom_range(0, 5)];
         id_funct      = fns[$urandom_range(0, 2)];
         ex_valid      = ($urandom_range(0, 9) < 8);
         ex_mem_read   = ($urandom_range(0, 9) < 4);
         ex_rt         = 5'($urandom_range(0, 7));
         ex_mispredict = ($urandom_range(0, 99) < 5);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
